// File: rtl/exp_1x1_ker_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : exp_1x1_ker_fetch_if
// Desc     : Memory burst-read bus and downstream FIFO write port of the
//            expand-1x1 kernel fetcher.
// Revision : 1.0
// ============================================================================
interface exp_1x1_ker_fetch_if;
    logic        mem_rd_o;
    logic [31:0] mem_rd_addr_o;
    logic [4:0]  mem_burst_o;
    logic        mem_waitrequest_i;
    logic        mem_rd_valid_i;
    logic [63:0] mem_rd_data_i;
    logic [7:0]  fifo_exp_1x1_data_count_i;
    logic        fifo_exp_1x1_clr_o;
    logic        fifo_exp_1x1_wr_en_o;
    logic [63:0] fifo_exp_1x1_wr_data_o;

    // fetcher side
    modport master (
        output mem_rd_o,
        output mem_rd_addr_o,
        output mem_burst_o,
        input  mem_waitrequest_i,
        input  mem_rd_valid_i,
        input  mem_rd_data_i,
        input  fifo_exp_1x1_data_count_i,
        output fifo_exp_1x1_clr_o,
        output fifo_exp_1x1_wr_en_o,
        output fifo_exp_1x1_wr_data_o
    );

    // memory / FIFO side
    modport slave (
        input  mem_rd_o,
        input  mem_rd_addr_o,
        input  mem_burst_o,
        output mem_waitrequest_i,
        output mem_rd_valid_i,
        output mem_rd_data_i,
        output fifo_exp_1x1_data_count_i,
        input  fifo_exp_1x1_clr_o,
        input  fifo_exp_1x1_wr_en_o,
        input  fifo_exp_1x1_wr_data_o
    );
endinterface
`default_nettype wire

// File: rtl/exp_1x1_ker_fetch.sv
`default_nettype none
// ============================================================================
// Module   : exp_1x1_ker_fetch
// Desc     : Fetches a layer's expand-1x1 kernels from memory in bursts of
//            64-bit beats and writes them, in order, into the downstream FIFO.
// Options  : define EXP1_KER_FETCH_ERR_EN for a sticky stray-beat error flag
//            on err_o (tied 0 otherwise).
// Revision : 1.0
// ============================================================================
module exp_1x1_ker_fetch #(
    parameter int BURST_LEN    = 16,
    parameter int FIFO_HIGH_WM = 224
) (
    input  wire                  clk_i,
    input  wire                  rst_n_i,
    input  wire                  start_i,
    input  wire                  exp_1x1_en_i,
    input  wire [31:0]           ker_base_addr_i,
    input  wire [11:0]           tot_exp1_ker_addr_limit_i,
    exp_1x1_ker_fetch_if.master  bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [11:0] c_burst_len   = 12'(BURST_LEN);
    localparam logic [4:0]  c_burst_len_s = 5'(BURST_LEN);
    localparam logic [10:0] c_high_wm     = 11'(FIFO_HIGH_WM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [11:0] r_remaining;
    logic [8:0]  r_outstanding;
    logic        r_mem_rd;
    logic [31:0] r_mem_addr;
    logic [4:0]  r_mem_burst;
    logic        r_clr;
    logic        r_wr_en;
    logic [63:0] r_wr_data;
    logic        r_busy;
    logic        r_done;

    logic        w_start_go;
    logic [4:0]  w_len;
    logic [10:0] w_need;
    logic        w_can_issue;
    logic        w_accept;
    logic        w_beat_ok;
    logic [8:0]  w_outstanding_nxt;
    logic        w_unused_limit_lsb;

    // Only the 64-bit beat count matters; the 32-bit LSB is absorbed by the
    // round-up in the beat computation.
    assign w_unused_limit_lsb = tot_exp1_ker_addr_limit_i[0];

    assign w_start_go = start_i && exp_1x1_en_i;

    assign w_len = (r_remaining >= c_burst_len) ? c_burst_len_s : r_remaining[4:0];

    // Issue only if the FIFO can absorb everything already requested plus this burst.
    assign w_need      = {3'b000, bus.fifo_exp_1x1_data_count_i}
                       + {2'b00, r_outstanding}
                       + {6'b000000, w_len};
    assign w_can_issue = (r_remaining != 12'd0) && (w_need <= c_high_wm);

    assign w_accept  = r_mem_rd && !bus.mem_waitrequest_i;

    // Beats nobody asked for (idle, or nothing outstanding) never reach the FIFO.
    assign w_beat_ok = bus.mem_rd_valid_i && (r_state != S_IDLE) && (r_outstanding != 9'd0);

    assign w_outstanding_nxt = r_outstanding
                             + (w_accept  ? {4'b0000, r_mem_burst} : 9'd0)
                             - (w_beat_ok ? 9'd1 : 9'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_outstanding <= 9'd0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= 64'd0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_wr_en       <= w_beat_ok;
            if (w_beat_ok) begin
                r_wr_data <= bus.mem_rd_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_remaining <= 12'd0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_burst <= 5'd0;
            r_clr       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_go) begin
                        r_state     <= S_CLEAR;
                        r_clr       <= 1'b1;
                        r_busy      <= 1'b1;
                        r_addr      <= ker_base_addr_i;
                        r_remaining <= {1'b0, tot_exp1_ker_addr_limit_i[11:1]} + 12'd1;
                    end
                end

                S_CLEAR: begin
                    r_clr   <= 1'b0;
                    r_state <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (r_mem_rd) begin
                        // Request held unchanged until the memory takes it.
                        if (!bus.mem_waitrequest_i) begin
                            r_mem_rd    <= 1'b0;
                            r_addr      <= r_addr + {24'd0, r_mem_burst, 3'b000};
                            r_remaining <= r_remaining - {7'd0, r_mem_burst};
                            if (r_remaining == {7'd0, r_mem_burst}) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end else if (w_can_issue) begin
                        r_mem_rd    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_burst <= w_len;
                    end
                end

                S_DRAIN: begin
                    // Wait for the last beat's FIFO write to leave the output register.
                    if ((r_outstanding == 9'd0) && !r_wr_en) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                    r_clr    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXP1_KER_FETCH_ERR_EN
    logic r_err;
    logic w_stray;

    assign w_stray = bus.mem_rd_valid_i && ((r_state == S_IDLE) || (r_outstanding == 9'd0));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_stray) begin
            r_err <= 1'b1;
        end else if (start_i && (r_state == S_IDLE)) begin
            r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign bus.mem_rd_o               = r_mem_rd;
    assign bus.mem_rd_addr_o          = r_mem_addr;
    assign bus.mem_burst_o            = r_mem_burst;
    assign bus.fifo_exp_1x1_clr_o     = r_clr;
    assign bus.fifo_exp_1x1_wr_en_o   = r_wr_en;
    assign bus.fifo_exp_1x1_wr_data_o = r_wr_data;
    assign busy_o                     = r_busy;
    assign done_o                     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_exp_1x1_ker_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_1x1_ker_fetch
// Desc     : Scoreboard bench for exp_1x1_ker_fetch with a simple memory model.
// Revision : 1.0
// ============================================================================
module tb_exp_1x1_ker_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        en;
    logic [31:0] base;
    logic [11:0] limit;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr_q[$];
    logic [4:0]  exp_len_q[$];
    logic [63:0] exp_data_q[$];
    logic [31:0] beat_q[$];

    int stall_cfg  = 0;
    int stray_cnt  = 0;
    int accepts    = 0;
    int rd_cycles  = 0;

    exp_1x1_ker_fetch_if bus();

    exp_1x1_ker_fetch #(
        .BURST_LEN    (16),
        .FIFO_HIGH_WM (224)
    ) dut (
        .clk_i                     (clk),
        .rst_n_i                   (rst_n),
        .start_i                   (start),
        .exp_1x1_en_i              (en),
        .ker_base_addr_i           (base),
        .tot_exp1_ker_addr_limit_i (limit),
        .bus                       (bus),
        .busy_o                    (busy),
        .done_o                    (done),
        .err_o                     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [31:0] a);
        return {~a, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic push_burst(input logic [31:0] a, input logic [4:0] l);
        exp_addr_q.push_back(a);
        exp_len_q.push_back(l);
    endtask

    task automatic push_data(input logic [31:0] b, input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 32'(8 * i);
            exp_data_q.push_back(pat(a));
        end
    endtask

    // Memory model: takes requests (with optional stall), returns beats in order.
    initial begin
        bit          in_req = 1'b0;
        int          stall_left = 0;
        logic [31:0] h_addr = 32'd0;
        logic [4:0]  h_len = 5'd0;
        logic [31:0] a;
        bus.mem_waitrequest_i = 1'b0;
        bus.mem_rd_valid_i    = 1'b0;
        bus.mem_rd_data_i     = 64'd0;
        forever begin
            @(negedge clk);
            if (beat_q.size() > 0) begin
                a = beat_q.pop_front();
                bus.mem_rd_valid_i = 1'b1;
                bus.mem_rd_data_i  = pat(a);
            end else if (stray_cnt > 0) begin
                stray_cnt--;
                bus.mem_rd_valid_i = 1'b1;
                bus.mem_rd_data_i  = 64'hDEAD_BEEF_0BAD_F00D;
            end else begin
                bus.mem_rd_valid_i = 1'b0;
            end
            if (bus.mem_rd_o) begin
                rd_cycles++;
                if (!in_req) begin
                    in_req     = 1'b1;
                    stall_left = stall_cfg;
                    stall_cfg  = 0;
                    h_addr     = bus.mem_rd_addr_o;
                    h_len      = bus.mem_burst_o;
                end else begin
                    check("req_stable", {27'd0, bus.mem_rd_addr_o, bus.mem_burst_o}, {27'd0, h_addr, h_len});
                end
                if (stall_left > 0) begin
                    bus.mem_waitrequest_i = 1'b1;
                    stall_left--;
                end else begin
                    bus.mem_waitrequest_i = 1'b0;
                    in_req = 1'b0;
                    accepts++;
                    if (exp_addr_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL burst: unexpected request addr %h len %0d", bus.mem_rd_addr_o, bus.mem_burst_o);
                    end else begin
                        check("burst_addr", 64'(bus.mem_rd_addr_o), 64'(exp_addr_q.pop_front()));
                        check("burst_len", 64'(bus.mem_burst_o), 64'(exp_len_q.pop_front()));
                    end
                    for (int i = 0; i < int'(bus.mem_burst_o); i++) begin
                        beat_q.push_back(bus.mem_rd_addr_o + 32'(8 * i));
                    end
                end
            end else begin
                bus.mem_waitrequest_i = 1'b0;
                in_req = 1'b0;
            end
        end
    end

    // FIFO write monitor
    initial begin
        forever begin
            @(negedge clk);
            if (bus.fifo_exp_1x1_wr_en_o) begin
                if (exp_data_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL fifo_write: unexpected write data %h, none expected", bus.fifo_exp_1x1_wr_data_o);
                end else begin
                    check("fifo_data", bus.fifo_exp_1x1_wr_data_o, exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [11:0] l);
        @(negedge clk);
        base  = b;
        limit = l;
        en    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clr_pulse", 64'(bus.fifo_exp_1x1_clr_o), 64'd1);
        check("busy_start", 64'(busy), 64'd1);
        @(negedge clk);
        check("clr_width", 64'(bus.fifo_exp_1x1_clr_o), 64'd0);
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(done), 64'd1);
        if (done) begin
            check("busy_in_done", 64'(busy), 64'd1);
            @(negedge clk);
            check("done_width", 64'(done), 64'd0);
            check("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    task automatic wait_accepts(input int target, input int bound);
        int k = 0;
        while (accepts < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        check("accept_seen", 64'(accepts >= target), 64'd1);
    endtask

    task automatic end_checks();
        check("bursts_left", 64'(exp_addr_q.size()), 64'd0);
        check("writes_left", 64'(exp_data_q.size()), 64'd0);
    endtask

    initial begin
        int a0;
        int r0;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b0;
        base  = 32'd0;
        limit = 12'd0;
        bus.fifo_exp_1x1_data_count_i = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_clr", 64'(bus.fifo_exp_1x1_clr_o), 64'd0);
        check("rst_wr_en", 64'(bus.fifo_exp_1x1_wr_en_o), 64'd0);
        check("rst_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_rd_addr_o), 64'd0);
        check("rst_mem_burst", 64'(bus.mem_burst_o), 64'd0);
        rst_n = 1'b1;

        // start with the layer not using expand-1x1 is ignored
        @(negedge clk);
        start = 1'b1;
        en    = 1'b0;
        base  = 32'h0000_7000;
        limit = 12'd63;
        @(negedge clk);
        start = 1'b0;
        check("en0_busy", 64'(busy), 64'd0);
        check("en0_clr", 64'(bus.fifo_exp_1x1_clr_o), 64'd0);
        repeat (3) @(negedge clk);
        check("en0_mem_rd", 64'(bus.mem_rd_o), 64'd0);

        // 32 beats: two full bursts; a second start mid-run is ignored
        push_burst(32'h0000_1000, 5'd16);
        push_burst(32'h0000_1080, 5'd16);
        push_data(32'h0000_1000, 32);
        a0 = accepts;
        do_start(32'h0000_1000, 12'd63);
        wait_accepts(a0 + 1, 50);
        start = 1'b1;
        base  = 32'h0000_9000;
        limit = 12'd5;
        @(negedge clk);
        start = 1'b0;
        check("restart_ignored_clr", 64'(bus.fifo_exp_1x1_clr_o), 64'd0);
        wait_done(300);
        end_checks();

        // 21 beats: 16 then a short burst of 5
        push_burst(32'h0000_4000, 5'd16);
        push_burst(32'h0000_4080, 5'd5);
        push_data(32'h0000_4000, 21);
        do_start(32'h0000_4000, 12'd40);
        wait_done(300);
        end_checks();

        // FIFO headroom throttling at the high watermark
        bus.fifo_exp_1x1_data_count_i = 8'd215;
        push_burst(32'h0000_2000, 5'd16);
        push_data(32'h0000_2000, 16);
        do_start(32'h0000_2000, 12'd31);
        r0 = rd_cycles;
        repeat (20) @(negedge clk);
        check("no_issue_215", 64'(rd_cycles - r0), 64'd0);
        bus.fifo_exp_1x1_data_count_i = 8'd209;
        repeat (10) @(negedge clk);
        check("no_issue_209", 64'(rd_cycles - r0), 64'd0);
        bus.fifo_exp_1x1_data_count_i = 8'd208;
        wait_done(300);
        end_checks();
        bus.fifo_exp_1x1_data_count_i = 8'd0;

        // 7-cycle waitrequest stall on a single burst
        stall_cfg = 7;
        push_burst(32'h0000_3000, 5'd16);
        push_data(32'h0000_3000, 16);
        a0 = accepts;
        r0 = rd_cycles;
        do_start(32'h0000_3000, 12'd31);
        wait_done(300);
        check("stall_accepts", 64'(accepts - a0), 64'd1);
        check("stall_req_cycles", 64'(rd_cycles - r0), 64'd8);
        end_checks();

        // asynchronous reset while the second burst is in flight
        push_burst(32'h0000_5000, 5'd16);
        push_burst(32'h0000_5080, 5'd16);
        push_data(32'h0000_5000, 32);
        a0 = accepts;
        do_start(32'h0000_5000, 12'd63);
        wait_accepts(a0 + 2, 100);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_clr", 64'(bus.fifo_exp_1x1_clr_o), 64'd0);
        check("arst_wr_en", 64'(bus.fifo_exp_1x1_wr_en_o), 64'd0);
        check("arst_wr_data", bus.fifo_exp_1x1_wr_data_o, 64'd0);
        check("arst_mem_rd", 64'(bus.mem_rd_o), 64'd0);
        check("arst_mem_addr", 64'(bus.mem_rd_addr_o), 64'd0);
        check("arst_mem_burst", 64'(bus.mem_burst_o), 64'd0);
        exp_addr_q.delete();
        exp_len_q.delete();
        exp_data_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (beat_q.size() > 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_mem_rd", 64'(bus.mem_rd_o), 64'd0);

        // new start after reset, with the address wrapping past 2^32
        push_burst(32'hFFFF_FFC0, 5'd16);
        push_burst(32'h0000_0040, 5'd8);
        push_data(32'hFFFF_FFC0, 24);
        do_start(32'hFFFF_FFC0, 12'd47);
        wait_done(300);
        end_checks();

        // stray beat while idle
        stray_cnt = 1;
        repeat (4) @(negedge clk);
`ifdef EXP1_KER_FETCH_ERR_EN
        check("stray_err", 64'(err), 64'd1);
`else
        check("stray_err", 64'(err), 64'd0);
`endif
        // smallest layer: limit 0 rounds up to a single beat; start clears err
        push_burst(32'h0000_6000, 5'd1);
        push_data(32'h0000_6000, 1);
        do_start(32'h0000_6000, 12'd0);
        check("err_cleared", 64'(err), 64'd0);
        wait_done(100);
        end_checks();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/exp_1x1_ker_fetch.md
EXP_1X1_KER_FETCH -- requirements
Module: exp_1x1_ker_fetch

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, meaning 64-bit beats per memory read burst (power of 2, 1..16).
REQ-002 SHALL have parameter FIFO_HIGH_WM, default 224, meaning the occupancy-plus-outstanding ceiling for issuing a burst.
REQ-003 clk_i  in  1  single clock; all logic on the rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  one-cycle pulse that begins a layer's kernel fetch.
REQ-006 exp_1x1_en_i  in  1  layer uses expand-1x1 kernels.
REQ-007 ker_base_addr_i  in  32  byte address of the first kernel word, 8-byte aligned.
REQ-008 tot_exp1_ker_addr_limit_i  in  12  (kernels*depth/4)-1 in 32-bit units.
REQ-009 fifo_exp_1x1_data_count_i  in  8  downstream FIFO occupancy.
REQ-010 fifo_exp_1x1_clr_o, fifo_exp_1x1_wr_en_o  out  1 each  FIFO clear and FIFO write.
REQ-011 fifo_exp_1x1_wr_data_o  out  64  FIFO write data.
REQ-012 mem_rd_o  out  1  burst read request.
REQ-013 mem_rd_addr_o  out  32  burst read address.
REQ-014 mem_burst_o  out  5  burst length of the request.
REQ-015 mem_waitrequest_i  in  1  memory stall signal.
REQ-016 mem_rd_valid_i  in  1  read data beat valid.
REQ-017 mem_rd_data_i  in  64  read data beat.
REQ-018 busy_o, done_o, err_o  out  1 each  status outputs.

Function
REQ-019 States SHALL be IDLE, CLEAR, ISSUE, DRAIN and DONE.
REQ-020 IDLE->CLEAR SHALL occur on start_i=1 with exp_1x1_en_i=1; start_i with exp_1x1_en_i=0 SHALL be ignored.
REQ-021 start_i SHALL be ignored in every state other than IDLE.
REQ-022 On start_i SHALL latch the config inputs and set remaining words = tot_exp1_ker_addr_limit_i[11:1]+1 (beats of 64 bits, rounded up).
REQ-023 CLEAR SHALL last exactly 1 cycle with fifo_exp_1x1_clr_o=1, then go to ISSUE.
REQ-024 In ISSUE a burst SHALL be issued only when fifo_exp_1x1_data_count_i + outstanding + len <= FIFO_HIGH_WM, where len = min(BURST_LEN, remaining).
REQ-025 A burst SHALL drive mem_rd_o=1, mem_rd_addr_o and mem_burst_o=len, held stable while mem_waitrequest_i=1.
REQ-026 A burst SHALL be accepted on the cycle where mem_rd_o=1 and mem_waitrequest_i=0.
REQ-027 On acceptance: address += len*8, remaining -= len, outstanding += len.
REQ-028 When remaining reaches 0 the FSM SHALL go to DRAIN.
REQ-029 Each mem_rd_valid_i beat SHALL be registered to fifo_exp_1x1_wr_data_o / fifo_exp_1x1_wr_en_o with 1-cycle latency, in arrival order, and SHALL decrement outstanding.
REQ-030 An acceptance and a valid beat in the same cycle SHALL update outstanding by len-1.
REQ-031 DRAIN->DONE SHALL occur when outstanding=0 and no write is pending.
REQ-032 DONE SHALL pulse done_o for 1 cycle, then return to IDLE.
REQ-033 busy_o SHALL be 1 in every state except IDLE.
REQ-034 outstanding SHALL be 9 bits wide and SHALL never wrap; the address SHALL wrap modulo 2^32.
REQ-035 A last burst shorter than BURST_LEN SHALL use len=remaining.

Reset
REQ-036 rst_n_i=0 SHALL asynchronously force IDLE, all counters to 0, and every output to 0.
REQ-037 Reset mid-burst SHALL discard in-flight beats; no FIFO write SHALL occur until the next CLEAR.

Configuration
REQ-038 Macro EXP1_KER_FETCH_ERR_EN: when defined, err_o SHALL be a sticky error flag, cleared by start_i or reset.
REQ-039 With EXP1_KER_FETCH_ERR_EN defined, err_o SHALL set on mem_rd_valid_i=1 while outstanding=0, or on mem_rd_valid_i=1 in IDLE; the stray beat SHALL NOT be written.
REQ-040 When EXP1_KER_FETCH_ERR_EN is undefined, err_o SHALL be tied 0 and stray beats SHALL be dropped silently.

Verification
REQ-041 limit=63, base=0x1000, count=0, no stalls -> bursts of 16 at 0x1000 and 0x1080; 32 FIFO writes in order; done_o pulse; clr_o pulse 1 cycle after start_i.
REQ-042 limit=40 -> 21 beats: bursts of 16 then 5; mem_burst_o=5 on the second; 21 writes.
REQ-043 count=215 held -> no mem_rd_o; count drops to 208 -> one 16-beat burst issued.
REQ-044 waitrequest=1 for 7 cycles -> address/burst stable throughout, accepted once, no duplicate request.
REQ-045 rst_n_i low during the second burst -> all outputs 0 immediately; beats returned after reset produce no FIFO writes; a new start_i works.
REQ-046 ERR_EN defined, valid beat in IDLE -> err_o=1 and no write; next start_i clears err_o.
